// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared constants and types for the game-over sequencing logic.
//   - default screen geometry
//   - colour constants (9-bit RGB, 3 bits per channel)
//   - FSM state encoding (plain 3-bit constants so older code that compares
//     raw state values keeps working)
//   - pixel bundle type used when muxing pixel sources
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int XSCREEN_DEF = 640;
    localparam int YSCREEN_DEF = 480;

    localparam logic [8:0] COLOR_BLACK = 9'b000_000_000;

    typedef logic [2:0] state_t;

    localparam state_t S_PLAY     = 3'd0;
    localparam state_t S_WIPE_IN  = 3'd1;
    localparam state_t S_SHOW     = 3'd2;
    localparam state_t S_HOLD     = 3'd3;
    localparam state_t S_WIPE_OUT = 3'd4;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [8:0] color;
        logic       write;
    } pixel_t;

    // Both wipe states share the raster counters and the constant colour.
    function automatic logic is_wipe(input state_t s);
        return (s == S_WIPE_IN) || (s == S_WIPE_OUT);
    endfunction

endpackage

// File: rtl/key_sync.sv
// ---------------------------------------------------------------------------
// key_sync
// Brings an asynchronous active-low push-button into the Clock domain and
// produces a one-cycle pulse on each press (falling edge of key_n).
//
// Ports
//   Clock       : system clock
//   Resetn      : synchronous active-low reset
//   key_n       : raw push-button, active-low, asynchronous to Clock
//   press_pulse : one Clock cycle high per press
// ---------------------------------------------------------------------------
module key_sync (
    input  logic Clock,
    input  logic Resetn,
    input  logic key_n,
    output logic press_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Reset to 1 (button released) so leaving reset never looks like a press.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign press_pulse = r_prev & ~r_sync2;

endmodule

// File: rtl/game_over_ctrl.sv
// ---------------------------------------------------------------------------
// game_over_ctrl
// Sequences the game-over flow: freezes the game on a collision, wipes the
// screen, lets the lose screen draw, waits for a restart press (after a
// minimum hold time), wipes again and restarts the game. Owns the single
// pixel stream to the VGA adapter and muxes it between the game renderer,
// the wipe raster and the lose screen.
//
// Ports
//   Clock, Resetn                         : clock, synchronous active-low reset
//   collision                             : player hit (level, only seen in PLAY)
//   restart_n                             : async push-button, active-low
//   game_x/y/color/write                  : game renderer pixel stream
//   lose_x/y/color/write, lose_complete   : lose screen pixel stream + done
//   lose_enable                           : request to the lose screen
//   game_freeze                           : game logic holds its state
//   game_restart                          : one-cycle game reinitialise pulse
//   VGA_x/y/color/write                   : registered pixel stream to VGA
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PLAY     | game running, game stream forwarded to VGA
// WIPE_IN  | game frozen, screen filled with WIPE_COLOR
// SHOW     | lose screen enabled and forwarded until it reports done
// HOLD     | lose screen kept up, waiting for hold time + restart press
// WIPE_OUT | screen filled with WIPE_COLOR, game restarted on last pixel
// ---------------------------------------------------------------------------
module game_over_ctrl
    import game_pkg::*;
#(
    parameter int         XSCREEN     = XSCREEN_DEF,
    parameter int         YSCREEN     = YSCREEN_DEF,
    parameter int         HOLD_CYCLES = 50_000_000,
    parameter logic [8:0] WIPE_COLOR  = COLOR_BLACK
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       collision,
    input  logic       restart_n,
    input  logic [9:0] game_x,
    input  logic [8:0] game_y,
    input  logic [8:0] game_color,
    input  logic       game_write,
    input  logic [9:0] lose_x,
    input  logic [8:0] lose_y,
    input  logic [8:0] lose_color,
    input  logic       lose_write,
    input  logic       lose_complete,
    output logic       lose_enable,
    output logic       game_freeze,
    output logic       game_restart,
    output logic [9:0] VGA_x,
    output logic [8:0] VGA_y,
    output logic [8:0] VGA_color,
    output logic       VGA_write
);

    localparam logic [9:0]  X_LAST   = 10'(XSCREEN - 1);
    localparam logic [8:0]  Y_LAST   = 9'(YSCREEN - 1);
    localparam logic [25:0] HOLD_MAX = 26'(HOLD_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_wipe_x;
    logic [8:0]  r_wipe_y;
    logic [25:0] r_hold;
    pixel_t      r_vga;
    pixel_t      w_pix;
    logic        w_wipe_last;
    logic        w_hold_done;
    logic        w_press;

    key_sync u_key_sync (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .key_n       (restart_n),
        .press_pulse (w_press)
    );

    assign w_wipe_last = (r_wipe_x == X_LAST) && (r_wipe_y == Y_LAST);
    assign w_hold_done = (r_hold == HOLD_MAX);

    // ------------------------------------------------------------------
    // Next-state logic. A press in HOLD before the hold time has elapsed
    // simply falls through: the pulse is gone next cycle, so nothing is
    // remembered.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_PLAY:     if (collision)                w_state_nxt = S_WIPE_IN;
            S_WIPE_IN:  if (w_wipe_last)              w_state_nxt = S_SHOW;
            S_SHOW:     if (lose_complete)            w_state_nxt = S_HOLD;
            S_HOLD:     if (w_hold_done && w_press)   w_state_nxt = S_WIPE_OUT;
            S_WIPE_OUT: if (w_wipe_last)              w_state_nxt = S_PLAY;
            default:                                  w_state_nxt = S_PLAY;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= S_PLAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Wipe raster, x fastest. Both counters wrap to 0 on the last pixel,
    // so the next wipe always starts from the origin without extra clears.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_wipe_x <= '0;
            r_wipe_y <= '0;
        end else if (is_wipe(r_state)) begin
            if (r_wipe_x == X_LAST) begin
                r_wipe_x <= '0;
                r_wipe_y <= (r_wipe_y == Y_LAST) ? '0 : r_wipe_y + 9'd1;
            end else begin
                r_wipe_x <= r_wipe_x + 10'd1;
            end
        end
    end

    // Hold timer: counts up from 0 on HOLD entry and saturates.
    always_ff @(posedge Clock) begin
        if (!Resetn || (r_state != S_HOLD)) begin
            r_hold <= '0;
        end else if (!w_hold_done) begin
            r_hold <= r_hold + 26'd1;
        end
    end

    // ------------------------------------------------------------------
    // Pixel source mux. In HOLD (and any unexpected state) the last
    // coordinates and colour are kept and only the write strobe drops.
    // ------------------------------------------------------------------
    always_comb begin
        w_pix       = r_vga;
        w_pix.write = 1'b0;
        case (r_state)
            S_PLAY: begin
                w_pix = '{x: game_x, y: game_y, color: game_color,
                          write: game_write};
            end
            S_WIPE_IN, S_WIPE_OUT: begin
                w_pix = '{x: r_wipe_x, y: r_wipe_y, color: WIPE_COLOR,
                          write: 1'b1};
            end
            S_SHOW: begin
                w_pix = '{x: lose_x, y: lose_y, color: lose_color,
                          write: lose_write};
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_vga <= '{x: '0, y: '0, color: WIPE_COLOR, write: 1'b0};
        end else begin
            r_vga <= w_pix;
        end
    end

    assign VGA_x     = r_vga.x;
    assign VGA_y     = r_vga.y;
    assign VGA_color = r_vga.color;
    assign VGA_write = r_vga.write;

    // Status outputs are decoded from registered state only, so they
    // change exactly on state boundaries and never glitch on inputs.
    assign lose_enable  = (r_state == S_SHOW) || (r_state == S_HOLD);
    assign game_freeze  = (r_state != S_PLAY);
    assign game_restart = (r_state == S_WIPE_OUT) && w_wipe_last;

endmodule

// File: doc/game_over_ctrl.md
GAME_OVER_CTRL -- requirements
Module: game_over_ctrl

Interface
REQ-001 SHALL have parameter XSCREEN, default 640, horizontal pixel count.
REQ-002 SHALL have parameter YSCREEN, default 480, vertical pixel count.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000, minimum cycles before a restart is accepted.
REQ-004 SHALL have parameter WIPE_COLOR, default 9'b000_000_000, colour used for full-screen wipes.
REQ-005 SHALL have port Clock, input, 1, system clock.
REQ-006 SHALL have port Resetn, input, 1, reset (synchronous, active-low).
REQ-007 SHALL have port collision, input, 1, level from game logic; high = player hit.
REQ-008 SHALL have port restart_n, input, 1, asynchronous push-button, active-low.
REQ-009 SHALL have ports game_x/game_y/game_color/game_write, inputs, 10/9/9/1, game renderer pixel stream.
REQ-010 SHALL have ports lose_x/lose_y/lose_color/lose_write, inputs, 10/9/9/1, lose-screen pixel stream.
REQ-011 SHALL have port lose_complete, input, 1, lose screen finished drawing.
REQ-012 SHALL have port lose_enable, output, 1, level request to the lose screen.
REQ-013 SHALL have port game_freeze, output, 1, high = game logic holds its state.
REQ-014 SHALL have port game_restart, output, 1, one-cycle pulse that reinitialises game logic.
REQ-015 SHALL have ports VGA_x/VGA_y/VGA_color/VGA_write, outputs, 10/9/9/1, pixel stream to the VGA adapter.

Function
REQ-016 SHALL implement FSM states PLAY, WIPE_IN, SHOW, HOLD, WIPE_OUT.
REQ-017 SHALL register all VGA outputs: source values at cycle N appear at cycle N+1.
REQ-018 In PLAY: VGA outputs = game stream delayed 1 cycle; game_freeze=0; lose_enable=0.
REQ-019 PLAY -> WIPE_IN when collision=1; game_freeze=1 from the next cycle until PLAY is re-entered.
REQ-020 In WIPE_IN/WIPE_OUT: writes WIPE_COLOR once per cycle, row-major, x fastest, from (0,0) to (XSCREEN-1,YSCREEN-1); VGA_write=1 for exactly XSCREEN*YSCREEN cycles; game/lose streams ignored.
REQ-021 Wipe counters: x wraps XSCREEN-1 -> 0 with y+1; after writing the final pixel, y wraps to 0 and the state advances.
REQ-022 WIPE_IN done -> SHOW; lose_enable=1 from the first SHOW cycle.
REQ-023 In SHOW: VGA outputs = lose stream delayed 1 cycle; SHOW -> HOLD on lose_complete=1.
REQ-024 In HOLD: lose_enable stays 1 (prevents redraw); VGA_write=0; hold counter increments from 0, saturating at HOLD_CYCLES.
REQ-025 HOLD -> WIPE_OUT only when hold counter = HOLD_CYCLES and a synchronised falling edge of restart_n occurs; presses earlier are discarded, not queued.
REQ-026 lose_enable=0 from the first WIPE_OUT cycle.
REQ-027 On the final WIPE_OUT pixel cycle, game_restart=1 for exactly one cycle; next state PLAY, game_freeze=0.
REQ-028 collision is ignored in every state except PLAY; collision held high through WIPE_OUT re-triggers WIPE_IN on the first PLAY cycle.
REQ-029 restart_n SHALL pass through a 2-flop synchroniser before edge detection; the edge detector is active in all states, but only consumed in HOLD.

Reset
REQ-030 On Resetn=0 at a clock edge: state=PLAY, counters=0, lose_enable=0, game_freeze=0, game_restart=0, VGA_write=0, VGA_x=0, VGA_y=0, VGA_color=WIPE_COLOR, synchroniser flops=1.
REQ-031 Reset mid-wipe or mid-SHOW SHALL abort immediately; no further VGA writes until PLAY forwards game writes.

Structure
REQ-032 XSCREEN/YSCREEN defaults, the colour constants and the FSM state encoding SHALL live in shared package game_pkg.
REQ-033 Synchroniser and falling-edge detector SHALL be sub-module key_sync (in: Clock, Resetn, key_n; out: press_pulse).
REQ-034 Hold counter SHALL be 26 bits; wipe counters SHALL be 10-bit x and 9-bit y.

Verification (XSCREEN=8, YSCREEN=4, HOLD_CYCLES=10)
REQ-035 Collision pulse in PLAY -> exactly 32 VGA_write cycles of colour 0, last at (7,3); then lose_enable=1.
REQ-036 In SHOW, lose_write=1 at (130,205) red -> VGA shows (130,205), 9'h1C0 one cycle later; lose_complete -> VGA_write=0.
REQ-037 restart_n pressed 5 cycles into HOLD -> ignored; pressed again at cycle 12 -> WIPE_OUT, lose_enable=0.
REQ-038 End of WIPE_OUT -> 32 writes, single-cycle game_restart coincident with last write, game_freeze=0 on the next cycle.
REQ-039 Resetn=0 during pixel 17 of WIPE_IN -> next cycle VGA_write=0, state PLAY, all outputs at reset values.
REQ-040 collision held high through WIPE_OUT -> WIPE_IN re-entered on the first cycle after PLAY.
